// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit:
// opcodes, functs, FSM states, instruction classes and datapath select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LW,
    CLS_SW,
    CLS_BRANCH,
    CLS_J,
    CLS_JR,
    CLS_JAL
  } instr_class_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] WSEL_ALU  = 2'b00;
  localparam logic [1:0] WSEL_MEM  = 2'b01;
  localparam logic [1:0] WSEL_LINK = 2'b10;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: maps the held instruction word to its
// class, ALU controls, destination register and an illegal-encoding flag.
module instr_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0]  ir,
  output instr_class_t cls,
  output logic [3:0]   alu_operation,
  output logic         alu_a_select,
  output logic         alu_b_select,
  output logic         extend_signed,
  output logic [4:0]   rf_waddr,
  output logic [1:0]   rf_wsel,
  output logic         illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign opcode        = ir[31:26];
  assign funct         = ir[5:0];
  assign rt            = ir[20:16];
  assign rd            = ir[15:11];
  assign unused_fields = ^{ir[25:21], ir[10:6]};

  always_comb begin
    cls           = CLS_ALU_R;
    alu_operation = ALU_ADD;
    alu_a_select  = 1'b0;
    alu_b_select  = 1'b0;
    extend_signed = 1'b0;
    rf_waddr      = rd;
    rf_wsel       = WSEL_ALU;
    illegal       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:  begin alu_operation = ALU_SLL; alu_a_select = 1'b1; end
          FN_SRL:  begin alu_operation = ALU_SRL; alu_a_select = 1'b1; end
          FN_SRA:  begin alu_operation = ALU_SRA; alu_a_select = 1'b1; end
          FN_SLLV: alu_operation = ALU_SLL;
          FN_SRLV: alu_operation = ALU_SRL;
          FN_SRAV: alu_operation = ALU_SRA;
          FN_JR:   cls = CLS_JR;
          FN_ADD:  alu_operation = ALU_ADD;
          FN_ADDU: alu_operation = ALU_ADDU;
          FN_SUB:  alu_operation = ALU_SUB;
          FN_SUBU: alu_operation = ALU_SUBU;
          FN_AND:  alu_operation = ALU_AND;
          FN_OR:   alu_operation = ALU_OR;
          FN_XOR:  alu_operation = ALU_XOR;
          FN_NOR:  alu_operation = ALU_NOR;
          FN_SLT:  alu_operation = ALU_SLT;
          FN_SLTU: alu_operation = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OP_J:   cls = CLS_J;
      OP_JAL: begin
        cls      = CLS_JAL;
        rf_waddr = 5'd31;
        rf_wsel  = WSEL_LINK;
      end
      OP_BEQ, OP_BNE: begin
        cls           = CLS_BRANCH;
        alu_operation = ALU_SUB;
        extend_signed = 1'b1;
      end
      OP_LW, OP_SW: begin
        cls           = (opcode == OP_LW) ? CLS_LW : CLS_SW;
        alu_b_select  = 1'b1;
        extend_signed = 1'b1;
        rf_waddr      = rt;
        rf_wsel       = (opcode == OP_LW) ? WSEL_MEM : WSEL_ALU;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        cls          = CLS_ALU_I;
        alu_b_select = 1'b1;
        rf_waddr     = rt;
        case (opcode)
          OP_ADDI:  begin alu_operation = ALU_ADD;  extend_signed = 1'b1; end
          OP_ADDIU: begin alu_operation = ALU_ADDU; extend_signed = 1'b1; end
          OP_SLTI:  begin alu_operation = ALU_SLT;  extend_signed = 1'b1; end
          OP_SLTIU: begin alu_operation = ALU_SLTU; extend_signed = 1'b1; end
          OP_ANDI:  alu_operation = ALU_AND;
          OP_ORI:   alu_operation = ALU_OR;
          OP_XORI:  alu_operation = ALU_XOR;
          default:  alu_operation = ALU_LUI;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// variable-latency memory handshakes, stall timeout and a retired-instruction count.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_write,
  output logic [1:0]       pc_select,
  output logic             rf_write,
  output logic [4:0]       rf_waddr,
  output logic [1:0]       rf_wsel,
  output logic             alu_a_select,
  output logic             alu_b_select,
  output logic             extend_signed,
  output logic [3:0]       alu_operation,
  output logic [2:0]       state,
  output logic             illegal_instr,
  output logic             error,
  output logic [CNT_W-1:0] retired_count
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state_q, state_d;
  logic [31:0]        ir_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [CNT_W-1:0]   retired_q;
  instr_class_t       cls;
  logic               illegal;
  logic               retire;
  logic               waiting;

  instr_decode u_decode (
    .ir            (ir_q),
    .cls           (cls),
    .alu_operation (alu_operation),
    .alu_a_select  (alu_a_select),
    .alu_b_select  (alu_b_select),
    .extend_signed (extend_signed),
    .rf_waddr      (rf_waddr),
    .rf_wsel       (rf_wsel),
    .illegal       (illegal)
  );

  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    pc_write      = 1'b0;
    pc_select     = PC_PLUS4;
    rf_write      = 1'b0;
    illegal_instr = 1'b0;
    retire        = 1'b0;
    waiting       = 1'b0;
    if (rst) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            pc_write = 1'b1;
            state_d  = DECODE;
          end else begin
            waiting = 1'b1;
          end
        end
        DECODE: begin
          if (illegal) begin
            illegal_instr = 1'b1;
            retire        = 1'b1;
            state_d       = FETCH;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          case (cls)
            CLS_BRANCH: begin
              pc_write  = branch_taken;
              pc_select = PC_BRANCH;
              retire    = 1'b1;
              state_d   = FETCH;
            end
            CLS_J, CLS_JAL: begin
              pc_write  = 1'b1;
              pc_select = PC_JUMP;
              rf_write  = (cls == CLS_JAL);
              retire    = 1'b1;
              state_d   = FETCH;
            end
            CLS_JR: begin
              pc_write  = 1'b1;
              pc_select = PC_REG;
              retire    = 1'b1;
              state_d   = FETCH;
            end
            CLS_LW, CLS_SW: state_d = MEM;
            default:        state_d = WB;
          endcase
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls == CLS_SW);
          if (dmem_ready) begin
            retire  = (cls == CLS_SW);
            state_d = (cls == CLS_SW) ? FETCH : WB;
          end else begin
            waiting = 1'b1;
          end
        end
        WB: begin
          rf_write = 1'b1;
          retire   = 1'b1;
          state_d  = FETCH;
        end
        ERROR:   state_d = ERROR;
        default: state_d = FETCH;
      endcase
      // The stalled cycle that hits the limit still shows its request; ERROR follows.
      if (waiting && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ERROR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && imem_ready) begin
        ir_q <= instruction;
      end
      tmo_q <= waiting ? tmo_q + TMO_W'(1) : '0;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign state         = state_q;
  assign error         = (state_q == ERROR);
  assign retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-scenario tasks with hand-computed
// expectations; DUT built with TIMEOUT_CYCLES=4 and a 4-bit retired counter.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        imem_ready;
  logic        dmem_ready;
  logic        branch_taken;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        pc_write;
  logic [1:0]  pc_select;
  logic        rf_write;
  logic [4:0]  rf_waddr;
  logic [1:0]  rf_wsel;
  logic        alu_a_select;
  logic        alu_b_select;
  logic        extend_signed;
  logic [3:0]  alu_operation;
  logic [2:0]  state;
  logic        illegal_instr;
  logic        error;
  logic [3:0]  retired_count;

  int          total = 0;
  int          bad   = 0;
  logic [3:0]  exp_ret;

  always #5 clk = ~clk;

  multicycle_controller #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .branch_taken  (branch_taken),
    .imem_req      (imem_req),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .pc_write      (pc_write),
    .pc_select     (pc_select),
    .rf_write      (rf_write),
    .rf_waddr      (rf_waddr),
    .rf_wsel       (rf_wsel),
    .alu_a_select  (alu_a_select),
    .alu_b_select  (alu_b_select),
    .extend_signed (extend_signed),
    .alu_operation (alu_operation),
    .state         (state),
    .illegal_instr (illegal_instr),
    .error         (error),
    .retired_count (retired_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instruction = '0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_req, dmem_req, dmem_we, pc_write, rf_write, illegal_instr} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=000000",
                      {imem_req, dmem_req, dmem_we, pc_write, rf_write, illegal_instr});
    end
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    tick(); rst = 1'b0; exp_ret = '0;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || imem_req !== 1'b1) begin
      bad++; $display("FAIL post_reset_fetch state=%0d imem_req=%b want 0/1", state, imem_req);
    end
    total++;
    if (retired_count !== 4'd0 || error !== 1'b0) begin
      bad++; $display("FAIL post_reset_regs retired=%0d error=%b want 0/0", retired_count, error);
    end
    tick();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [2:0]  abx;
    logic [4:0]  wa;
  } dec_vec_t;

  task automatic test_decode();
    dec_vec_t tbl [7];
    tbl[0] = '{32'h00221821, 4'b0001, 3'b000, 5'd3};   // addu $3,$1,$2
    tbl[1] = '{32'h3422FFFF, 4'b0101, 3'b010, 5'd2};   // ori  $2,$1,0xffff
    tbl[2] = '{32'h3C031234, 4'b1101, 3'b010, 5'd3};   // lui  $3,0x1234
    tbl[3] = '{32'h2928FFFF, 4'b1000, 3'b011, 5'd8};   // slti $8,$9,-1
    tbl[4] = '{32'h00052080, 4'b1010, 3'b100, 5'd4};   // sll  $4,$5,2
    tbl[5] = '{32'h018B5007, 4'b1100, 3'b000, 5'd10};  // srav $10,$11,$12
    tbl[6] = '{32'h2C410001, 4'b1001, 3'b011, 5'd1};   // sltiu $1,$2,1
    for (int i = 0; i < 7; i++) begin
      instruction = tbl[i].instr; imem_ready = 1'b1;
      @(negedge clk);
      total++;
      if (state !== 3'd0 || pc_write !== 1'b1 || pc_select !== 2'b00) begin
        bad++; $display("FAIL dec%0d_fetch state=%0d pc_write=%b pc_select=%b want 0/1/00",
                        i, state, pc_write, pc_select);
      end
      tick(); imem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (state !== 3'd1) begin bad++; $display("FAIL dec%0d_state got=%0d want=1", i, state); end
      total++;
      if (alu_operation !== tbl[i].op) begin
        bad++; $display("FAIL dec%0d_aluop got=%b want=%b", i, alu_operation, tbl[i].op);
      end
      total++;
      if ({alu_a_select, alu_b_select, extend_signed} !== tbl[i].abx) begin
        bad++; $display("FAIL dec%0d_sel got=%b want=%b", i,
                        {alu_a_select, alu_b_select, extend_signed}, tbl[i].abx);
      end
      total++;
      if (rf_waddr !== tbl[i].wa) begin
        bad++; $display("FAIL dec%0d_waddr got=%0d want=%0d", i, rf_waddr, tbl[i].wa);
      end
      tick();
      @(negedge clk);
      total++;
      if (state !== 3'd2) begin bad++; $display("FAIL dec%0d_exec got=%0d want=2", i, state); end
      tick();
      @(negedge clk);
      total++;
      if (state !== 3'd4 || rf_write !== 1'b1 || rf_wsel !== 2'b00) begin
        bad++; $display("FAIL dec%0d_wb state=%0d rf_write=%b rf_wsel=%b want 4/1/00",
                        i, state, rf_write, rf_wsel);
      end
      tick(); exp_ret++;
      @(negedge clk);
      total++;
      if (state !== 3'd0 || retired_count !== exp_ret) begin
        bad++; $display("FAIL dec%0d_retire state=%0d retired=%0d want 0/%0d",
                        i, state, retired_count, exp_ret);
      end
      tick();
    end
  endtask

  task automatic test_lw_wait();
    int nreq;
    instruction = 32'h8C850008; imem_ready = 1'b1;  // lw $5,8($4)
    @(negedge clk);
    tick(); imem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (alu_b_select !== 1'b1 || extend_signed !== 1'b1 || alu_operation !== 4'b0000) begin
      bad++; $display("FAIL lw_decode b=%b ext=%b op=%b want 1/1/0000",
                      alu_b_select, extend_signed, alu_operation);
    end
    tick(); tick();
    nreq = 0;
    for (int k = 0; k < 4; k++) begin
      dmem_ready = (k == 3);
      @(negedge clk);
      total++;
      if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b0) begin
        bad++; $display("FAIL lw_mem%0d state=%0d dmem_req=%b dmem_we=%b want 3/1/0",
                        k, state, dmem_req, dmem_we);
      end
      if (dmem_req === 1'b1) nreq++;
      tick();
    end
    dmem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 3'd4 || rf_write !== 1'b1 || rf_wsel !== 2'b01 || rf_waddr !== 5'd5 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL lw_wb state=%0d rf_write=%b wsel=%b waddr=%0d dmem_req=%b want 4/1/01/5/0",
                      state, rf_write, rf_wsel, rf_waddr, dmem_req);
    end
    total++;
    if (nreq != 4) begin bad++; $display("FAIL lw_req_cycles got=%0d want=4", nreq); end
    tick(); exp_ret++;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || retired_count !== exp_ret) begin
      bad++; $display("FAIL lw_retire state=%0d retired=%0d want 0/%0d", state, retired_count, exp_ret);
    end
    tick();
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      instruction = 32'h10220004; imem_ready = 1'b1;  // beq $1,$2,4
      @(negedge clk);
      tick(); imem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (alu_operation !== 4'b0010 || extend_signed !== 1'b1) begin
        bad++; $display("FAIL beq%0d_decode op=%b ext=%b want 0010/1", t, alu_operation, extend_signed);
      end
      tick(); branch_taken = (t == 0);
      @(negedge clk);
      total++;
      if (state !== 3'd2 || pc_write !== (t == 0) || pc_select !== 2'b01 || rf_write !== 1'b0) begin
        bad++; $display("FAIL beq%0d_exec state=%0d pc_write=%b pc_select=%b rf_write=%b want 2/%0d/01/0",
                        t, state, pc_write, pc_select, rf_write, (t == 0));
      end
      tick(); branch_taken = 1'b0; exp_ret++;
      @(negedge clk);
      total++;
      if (state !== 3'd0 || retired_count !== exp_ret) begin
        bad++; $display("FAIL beq%0d_retire state=%0d retired=%0d want 0/%0d",
                        t, state, retired_count, exp_ret);
      end
      tick();
    end
  endtask

  task automatic test_jumps();
    logic [31:0] ins [3];
    logic [1:0]  psel [3];
    logic        rfw [3];
    ins[0] = 32'h08000040; psel[0] = 2'b10; rfw[0] = 1'b0;  // j
    ins[1] = 32'h0C000100; psel[1] = 2'b10; rfw[1] = 1'b1;  // jal 0x100
    ins[2] = 32'h03E00008; psel[2] = 2'b11; rfw[2] = 1'b0;  // jr $31
    for (int i = 0; i < 3; i++) begin
      instruction = ins[i]; imem_ready = 1'b1;
      @(negedge clk);
      tick(); imem_ready = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      total++;
      if (state !== 3'd2 || pc_write !== 1'b1 || pc_select !== psel[i] || rf_write !== rfw[i]) begin
        bad++; $display("FAIL jump%0d_exec state=%0d pc_write=%b pc_select=%b rf_write=%b want 2/1/%b/%b",
                        i, state, pc_write, pc_select, rf_write, psel[i], rfw[i]);
      end
      if (rfw[i]) begin
        total++;
        if (rf_waddr !== 5'd31 || rf_wsel !== 2'b10) begin
          bad++; $display("FAIL jal_link waddr=%0d wsel=%b want 31/10", rf_waddr, rf_wsel);
        end
      end
      tick(); exp_ret++;
      @(negedge clk);
      total++;
      if (state !== 3'd0 || retired_count !== exp_ret) begin
        bad++; $display("FAIL jump%0d_retire state=%0d retired=%0d want 0/%0d",
                        i, state, retired_count, exp_ret);
      end
      tick();
    end
  endtask

  task automatic test_sw();
    instruction = 32'hACE60004; imem_ready = 1'b1;  // sw $6,4($7)
    @(negedge clk);
    tick(); imem_ready = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    total++;
    if (state !== 3'd2 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL sw_exec state=%0d dmem_req=%b want 2/0", state, dmem_req);
    end
    tick(); dmem_ready = 1'b1;
    @(negedge clk);
    total++;
    if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || rf_write !== 1'b0) begin
      bad++; $display("FAIL sw_mem state=%0d dmem_req=%b dmem_we=%b rf_write=%b want 3/1/1/0",
                      state, dmem_req, dmem_we, rf_write);
    end
    tick(); dmem_ready = 1'b0; exp_ret++;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || retired_count !== exp_ret) begin
      bad++; $display("FAIL sw_retire state=%0d retired=%0d want 0/%0d", state, retired_count, exp_ret);
    end
    tick();
  endtask

  task automatic test_rst_abort();
    instruction = 32'hACE60004; imem_ready = 1'b1;
    @(negedge clk);
    tick(); imem_ready = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick(); dmem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 3'd3 || dmem_we !== 1'b1) begin
      bad++; $display("FAIL abort_pre state=%0d dmem_we=%b want 3/1", state, dmem_we);
    end
    tick(); rst = 1'b1;
    @(negedge clk);
    total++;
    if ({dmem_req, dmem_we, rf_write, pc_write, imem_req} !== 5'b0) begin
      bad++; $display("FAIL abort_strobes got=%b want=00000", {dmem_req, dmem_we, rf_write, pc_write, imem_req});
    end
    tick(); rst = 1'b0; exp_ret = '0;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || retired_count !== 4'd0) begin
      bad++; $display("FAIL abort_post state=%0d retired=%0d want 0/0", state, retired_count);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2];
    ins[0] = 32'hFC000000;  // opcode 0x3f
    ins[1] = 32'h00000001;  // R-type funct 0x01
    for (int i = 0; i < 2; i++) begin
      instruction = ins[i]; imem_ready = 1'b1;
      @(negedge clk);
      tick(); imem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (state !== 3'd1 || illegal_instr !== 1'b1) begin
        bad++; $display("FAIL illegal%0d_decode state=%0d illegal=%b want 1/1", i, state, illegal_instr);
      end
      tick(); exp_ret++;
      @(negedge clk);
      total++;
      if (state !== 3'd0 || illegal_instr !== 1'b0 || retired_count !== exp_ret) begin
        bad++; $display("FAIL illegal%0d_after state=%0d illegal=%b retired=%0d want 0/0/%0d",
                        i, state, illegal_instr, retired_count, exp_ret);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick(); rst = 1'b0;
    instruction = '0; imem_ready = 1'b1;  // sll r0 nop, 4 cycles each
    repeat (60) tick();
    @(negedge clk);
    total++;
    if (state !== 3'd0 || retired_count !== 4'd15) begin
      bad++; $display("FAIL wrap_full state=%0d retired=%0d want 0/15", state, retired_count);
    end
    repeat (4) tick();
    @(negedge clk);
    total++;
    if (state !== 3'd0 || retired_count !== 4'd0) begin
      bad++; $display("FAIL wrap_zero state=%0d retired=%0d want 0/0", state, retired_count);
    end
    imem_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    tick(); rst = 1'b0; imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (state !== 3'd0 || error !== 1'b0 || imem_req !== 1'b1) begin
        bad++; $display("FAIL tmo_wait%0d state=%0d error=%b imem_req=%b want 0/0/1",
                        k, state, error, imem_req);
      end
      tick();
    end
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (state !== 3'd7 || error !== 1'b1 || {imem_req, pc_write, rf_write, dmem_req} !== 4'b0) begin
        bad++; $display("FAIL tmo_error%0d state=%0d error=%b strobes=%b want 7/1/0000",
                        k, state, error, {imem_req, pc_write, rf_write, dmem_req});
      end
      tick();
    end
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    tick(); rst = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || error !== 1'b0) begin
      bad++; $display("FAIL tmo_clear state=%0d error=%b want 0/0", state, error);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_sw();
    test_rst_abort();
    test_illegal();
    test_wrap();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
